// File: rtl/uart_io_pkg.sv
// uart_io_pkg
// Shared definitions for the board UART reader/writer pair: byte width,
// default word count, the writer state encoding and a bytes-per-word helper.
// Optional feature macro: UART_WRITER_CKSUM_EN adds the ST_CKSUM state.
package uart_io_pkg;

  localparam int BYTE_W        = 8;
  localparam int DEF_NUM_WORDS = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_GAP   = 3'd2,
    ST_DONE  = 3'd3
`ifdef UART_WRITER_CKSUM_EN
    , ST_CKSUM = 3'd4
`endif
  } writer_state_t;

  function automatic int bytes_per_word(input int word_w);
    return word_w / BYTE_W;
  endfunction

endpackage

// File: rtl/uart_byte_strobe.sv
// uart_byte_strobe
// Waits for txready while a byte is offered and emits it as a registered
// byte with a one-cycle txclk strobe. The parent withdraws send_i after the
// strobe, which guarantees the low cycle between strobes.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   send_i         parent offers byte_i this cycle
//   byte_i         byte to transmit
//   txready_i      UART can accept a byte
//   txdata_o       registered byte, held between strobes
//   txclk_o        registered one-cycle strobe
//   fire_o         byte accepted on this clock edge (combinational)
module uart_byte_strobe
  import uart_io_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              send_i,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic              txready_i,
  output logic [BYTE_W-1:0] txdata_o,
  output logic              txclk_o,
  output logic              fire_o
);

  logic [BYTE_W-1:0] txdata_q, txdata_d;
  logic              txclk_q, txclk_d;

  assign fire_o = send_i & txready_i;

  always_comb begin
    txclk_d  = fire_o;
    txdata_d = fire_o ? byte_i : txdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      txdata_q <= '0;
      txclk_q  <= 1'b0;
    end else begin
      txdata_q <= txdata_d;
      txclk_q  <= txclk_d;
    end
  end

  assign txdata_o = txdata_q;
  assign txclk_o  = txclk_q;

endmodule

// File: rtl/uart_word_writer.sv
// uart_word_writer
// Serialises NUM_WORDS words of WORD_W bits onto the UART transmit port,
// LSB-first within a word, word 0 first. Words are snapshotted at run start.
// Optional feature macro: UART_WRITER_CKSUM_EN appends an XOR checksum byte.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   start          level run request, accepted in IDLE
//   words          data to send, sampled only at run start
//   txready        UART can accept a byte
//   txdata, txclk  byte and one-cycle strobe to the UART
//   busy           run in progress
//   complete       run finished, held until start drops
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | offering the current byte, waiting for txready
// GAP   | strobe low cycle, advance indices
// CKSUM | offering the checksum byte (optional)
// DONE  | complete held until start drops
module uart_word_writer
  import uart_io_pkg::*;
#(
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int WORD_W    = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] words [NUM_WORDS],
  input  logic              txready,
  output logic [7:0]        txdata,
  output logic              txclk,
  output logic              busy,
  output logic              complete
);

  localparam int BPW  = bytes_per_word(WORD_W);
  localparam int WI_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int BI_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [WI_W-1:0] LAST_WORD = WI_W'(NUM_WORDS - 1);
  localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(BPW - 1);

  writer_state_t     state_q, state_d;
  logic [WI_W-1:0]   word_idx_q, word_idx_d;
  logic [BI_W-1:0]   byte_idx_q, byte_idx_d;
  logic [WORD_W-1:0] shadow_q [NUM_WORDS];
  logic              busy_q, busy_d;
  logic              complete_q, complete_d;
  logic              load_shadow;
  logic              send;
  logic              fire;
  logic              last_byte;
  logic [WORD_W-1:0] cur_word;
  logic [BYTE_W-1:0] data_byte;
  logic [BYTE_W-1:0] send_byte;

`ifdef UART_WRITER_CKSUM_EN
  logic [BYTE_W-1:0] cksum_q, cksum_d;
  logic              cksum_sent_q, cksum_sent_d;
`endif

  assign cur_word  = shadow_q[word_idx_q];
  assign data_byte = cur_word[BYTE_W*byte_idx_q +: BYTE_W];
  assign last_byte = (word_idx_q == LAST_WORD) && (byte_idx_q == LAST_BYTE);

  always_comb begin
    state_d     = state_q;
    word_idx_d  = word_idx_q;
    byte_idx_d  = byte_idx_q;
    busy_d      = busy_q;
    complete_d  = complete_q;
    load_shadow = 1'b0;
    send        = 1'b0;
    send_byte   = data_byte;
`ifdef UART_WRITER_CKSUM_EN
    cksum_d      = cksum_q;
    cksum_sent_d = cksum_sent_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load_shadow = 1'b1;
          word_idx_d  = '0;
          byte_idx_d  = '0;
          busy_d      = 1'b1;
          state_d     = ST_LOAD;
`ifdef UART_WRITER_CKSUM_EN
          cksum_d      = '0;
          cksum_sent_d = 1'b0;
`endif
        end
      end
      ST_LOAD: begin
        send = 1'b1;
        if (fire) begin
          state_d = ST_GAP;
`ifdef UART_WRITER_CKSUM_EN
          cksum_d = cksum_q ^ data_byte;
`endif
        end
      end
      ST_GAP: begin
`ifdef UART_WRITER_CKSUM_EN
        // The GAP after the checksum byte ends the run.
        if (cksum_sent_q) begin
          state_d    = ST_DONE;
          busy_d     = 1'b0;
          complete_d = 1'b1;
        end else
`endif
        if (last_byte) begin
          word_idx_d = '0;
          byte_idx_d = '0;
`ifdef UART_WRITER_CKSUM_EN
          state_d    = ST_CKSUM;
`else
          state_d    = ST_DONE;
          busy_d     = 1'b0;
          complete_d = 1'b1;
`endif
        end else begin
          state_d = ST_LOAD;
          if (byte_idx_q == LAST_BYTE) begin
            byte_idx_d = '0;
            word_idx_d = word_idx_q + 1'b1;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end
`ifdef UART_WRITER_CKSUM_EN
      ST_CKSUM: begin
        send      = 1'b1;
        send_byte = cksum_q;
        if (fire) begin
          state_d      = ST_GAP;
          cksum_sent_d = 1'b1;
        end
      end
`endif
      ST_DONE: begin
        if (!start) begin
          complete_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
`ifdef UART_WRITER_CKSUM_EN
      cksum_q      <= '0;
      cksum_sent_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      busy_q     <= busy_d;
      complete_q <= complete_d;
`ifdef UART_WRITER_CKSUM_EN
      cksum_q      <= cksum_d;
      cksum_sent_q <= cksum_sent_d;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_WORDS; i++) shadow_q[i] <= '0;
    end else if (load_shadow) begin
      shadow_q <= words;
    end
  end

  uart_byte_strobe u_strobe (
    .clk       (clk),
    .reset_n   (reset_n),
    .send_i    (send),
    .byte_i    (send_byte),
    .txready_i (txready),
    .txdata_o  (txdata),
    .txclk_o   (txclk),
    .fire_o    (fire)
  );

  assign busy     = busy_q;
  assign complete = complete_q;

endmodule

// File: tb/tb_uart_word_writer.sv
// Testbench for uart_word_writer (default parameters).
module tb_uart_word_writer;

  localparam int NDATA = 16;
`ifdef UART_WRITER_CKSUM_EN
  localparam int NSTROBE = NDATA + 1;
`else
  localparam int NSTROBE = NDATA;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        txready = 1'b0;
  logic [31:0] words [4];
  logic [7:0]  txdata;
  logic        txclk;
  logic        busy;
  logic        complete;

  int checks = 0;
  int failures = 0;

  logic [7:0] strobes [$];
  int         dbl_high = 0;
  logic       prev_txclk = 1'b0;

  typedef struct {
    int         edge_n;
    logic       txclk;
    logic [7:0] txdata;
    logic       busy;
    logic       complete;
  } vec_t;

  vec_t vecs [$];

  uart_word_writer dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .words    (words),
    .txready  (txready),
    .txdata   (txdata),
    .txclk    (txclk),
    .busy     (busy),
    .complete (complete)
  );

  always #5 clk = ~clk;

  // Strobe recorder, sampled 1 ns after each rising edge.
  always @(posedge clk) begin
    #1;
    if (txclk === 1'b1) begin
      strobes.push_back(txdata);
      if (prev_txclk === 1'b1) dbl_high++;
    end
    prev_txclk = txclk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // 0x01..0x10 for data bytes; the XOR of 01..10 is 0x10.
  function automatic logic [7:0] exp_byte(input int k);
    if (k < NDATA) return 8'(k + 1);
    return 8'h10;
  endfunction

  task automatic wait_done(output int n);
    n = 0;
    while (complete !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("complete within bound", {31'd0, complete}, 32'd1);
  endtask

  task automatic check_stream(input string name);
    chk($sformatf("%s strobe count", name), strobes.size(), NSTROBE);
    for (int i = 0; i < NSTROBE; i++) begin
      if (i < strobes.size())
        chk($sformatf("%s byte %0d", name, i), {24'd0, strobes[i]}, {24'd0, exp_byte(i)});
      else
        chk($sformatf("%s byte %0d missing", name, i), 32'hFFFF_FFFF, {24'd0, exp_byte(i)});
    end
  endtask

  task automatic set_words();
    words[0] = 32'h04030201;
    words[1] = 32'h08070605;
    words[2] = 32'h0C0B0A09;
    words[3] = 32'h100F0E0D;
  endtask

  initial begin
    int n;

    vecs.push_back('{edge_n: 0, txclk: 1'b0, txdata: 8'h00, busy: 1'b1, complete: 1'b0});
    for (int k = 0; k < NSTROBE; k++) begin
      vecs.push_back('{edge_n: 1 + 2*k, txclk: 1'b1, txdata: exp_byte(k),
                       busy: 1'b1, complete: 1'b0});
      vecs.push_back('{edge_n: 2 + 2*k, txclk: 1'b0, txdata: exp_byte(k),
                       busy: (k != NSTROBE-1), complete: (k == NSTROBE-1)});
    end

    set_words();
    #12;
    chk("reset outputs", {21'd0, txdata, txclk, busy, complete}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    txready = 1'b1;

    // start low: nothing happens
    repeat (3) tick();
    chk("idle busy", {31'd0, busy}, 32'd0);
    chk("idle strobes", strobes.size(), 0);

    // Nominal run, edge-by-edge against the table
    start = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      tick();
      chk($sformatf("nominal edge %0d", vecs[i].edge_n),
          {21'd0, txclk, txdata, busy, complete},
          {21'd0, vecs[i].txclk, vecs[i].txdata, vecs[i].busy, vecs[i].complete});
    end
    check_stream("nominal");

    // Handshake exit: start held keeps complete and sends nothing more
    repeat (4) begin
      tick();
      chk("hold complete", {31'd0, complete}, 32'd1);
    end
    chk("hold no new strobes", strobes.size(), NSTROBE);
    start = 1'b0;
    tick();
    chk("exit complete", {31'd0, complete}, 32'd0);
    chk("exit busy", {31'd0, busy}, 32'd0);
    strobes.delete();
    start = 1'b1;
    wait_done(n);
    chk("second run latency", n, 2*NSTROBE + 1);
    check_stream("second run");

    // Backpressure before byte 3, and txready low during a GAP
    start = 1'b0;
    tick();
    strobes.delete();
    start = 1'b1;
    tick();
    repeat (6) tick();
    chk("bp strobes before stall", strobes.size(), 3);
    txready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp stall %0d txclk", i), {31'd0, txclk}, 32'd0);
    end
    txready = 1'b1;
    tick();
    chk("bp resume", {23'd0, txclk, txdata}, {23'd0, 1'b1, 8'h04});
    txready = 1'b0;
    tick();
    chk("gap low txready", {31'd0, txclk}, 32'd0);
    txready = 1'b1;
    tick();
    chk("after gap", {23'd0, txclk, txdata}, {23'd0, 1'b1, 8'h05});
    wait_done(n);
    check_stream("backpressure");

    // Snapshot: words overwritten two cycles after start
    start = 1'b0;
    tick();
    strobes.delete();
    start = 1'b1;
    tick();
    tick();
    tick();
    for (int i = 0; i < 4; i++) words[i] = 32'hFFFF_FFFF;
    wait_done(n);
    check_stream("snapshot");
    set_words();

    // start dropping mid-run is ignored
    start = 1'b0;
    tick();
    strobes.delete();
    start = 1'b1;
    tick();
    repeat (3) tick();
    start = 1'b0;
    wait_done(n);
    chk("start drop latency", n, 2*NSTROBE - 3);
    tick();
    chk("start drop exit", {30'd0, busy, complete}, 32'd0);
    check_stream("start drop");

    // Reset mid-run after byte 5
    strobes.delete();
    start = 1'b1;
    tick();
    repeat (9) tick();
    chk("pre-reset strobe", {23'd0, txclk, txdata}, {23'd0, 1'b1, 8'h05});
    #1 reset_n = 1'b0;
    #1;
    chk("async reset", {21'd0, txdata, txclk, busy, complete}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    strobes.delete();
    wait_done(n);
    chk("post-reset latency", n, 2*NSTROBE + 1);
    check_stream("post-reset");

    chk("txclk single-cycle", dbl_high, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
